// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU front end: widths, ALU control codes
// and the legality check used to flag undefined codes.
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 4;

   typedef enum logic [CTRL_W-1:0] {
      AluAdd  = 4'b0000,
      AluSll  = 4'b0001,
      AluSlt  = 4'b0010,
      AluSltu = 4'b0011,
      AluXor  = 4'b0100,
      AluSrl  = 4'b0101,
      AluOr   = 4'b0110,
      AluAnd  = 4'b0111,
      AluSub  = 4'b1000,
      AluLui  = 4'b1001,
      AluSra  = 4'b1101
   } alu_ctrl_e;

   function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] ctrl);
      case (ctrl)
         AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl,
         AluOr, AluAnd, AluSub, AluLui, AluSra: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two requesters and the shared-ALU front end.
// Bit i of each 2-bit vector belongs to requester i.
interface alu_share_ctrl_if;
   import alu_pkg::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [CTRL_W-1:0] req_ctrl0;
   logic [CTRL_W-1:0] req_ctrl1;
   logic [DATA_W-1:0] req_src1_0;
   logic [DATA_W-1:0] req_src1_1;
   logic [DATA_W-1:0] req_src2_0;
   logic [DATA_W-1:0] req_src2_1;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_data0;
   logic [DATA_W-1:0] rsp_data1;
   logic [1:0]        rsp_err;

   modport master (
      output req_valid, req_ctrl0, req_ctrl1, req_src1_0, req_src1_1,
             req_src2_0, req_src2_1, rsp_ready,
      input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
   );

   modport slave (
      input  req_valid, req_ctrl0, req_ctrl1, req_src1_0, req_src1_1,
             req_src2_0, req_src2_1, rsp_ready,
      output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err
   );

endinterface

// File: rtl/alu.sv
// Purely combinational integer ALU. Undefined control codes fall back to addition;
// flagging them is left to the caller.
module alu import alu_pkg::*; (
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_src1,
   input  logic [DATA_W-1:0] i_src2,
   output logic [DATA_W-1:0] o_result
);

   logic [4:0] w_shamt;

   assign w_shamt = i_src2[4:0];

   always_comb begin
      o_result = i_src1 + i_src2;
      case (i_ctrl)
         AluSub:  o_result = i_src1 - i_src2;
         AluSll:  o_result = i_src1 << w_shamt;
         AluSlt:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
         AluSltu: o_result = {{(DATA_W-1){1'b0}}, (i_src1 < i_src2)};
         AluXor:  o_result = i_src1 ^ i_src2;
         AluSrl:  o_result = i_src1 >> w_shamt;
         AluSra:  o_result = $signed(i_src1) >>> w_shamt;
         AluOr:   o_result = i_src1 | i_src2;
         AluAnd:  o_result = i_src1 & i_src2;
         AluLui:  o_result = i_src2;
         default: o_result = i_src1 + i_src2;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and flips to
// the other one after every grant; grants are forced off while in reset.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_elig,
   output logic [1:0] o_grant
);

   logic r_ptr;
   logic w_ptr_d;

   always_comb begin
      o_grant = 2'b00;
      w_ptr_d = r_ptr;
      if (!i_rst) begin
         if (i_elig == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
         end else begin
            o_grant = i_elig;
         end
      end
      // Granting requester 0 prefers 1 next time, and vice versa.
      if (o_grant != 2'b00) begin
         w_ptr_d = o_grant[0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= 1'b0;
      end else begin
         r_ptr <= w_ptr_d;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: round-robin grant, operand mux, and a
// one-entry registered response slot per requester with drain-and-refill.
module alu_share_ctrl import alu_pkg::*; (
   input logic             i_clk,
   input logic             i_rst,
   alu_share_ctrl_if.slave io_bus
);

   logic [1:0]        w_elig;
   logic [1:0]        w_grant;
   logic              w_sel;
   logic [CTRL_W-1:0] w_ctrl;
   logic [DATA_W-1:0] w_src1;
   logic [DATA_W-1:0] w_src2;
   logic [DATA_W-1:0] w_result;
   logic              w_err;

   logic [1:0]        r_rsp_valid;
   logic [1:0]        r_rsp_err;
   logic [DATA_W-1:0] r_rsp_data [2];

   // A full slot is still eligible when it is being drained in the same cycle.
   assign w_elig = io_bus.req_valid & (~r_rsp_valid | io_bus.rsp_ready);

   rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_elig  (w_elig),
      .o_grant (w_grant)
   );

   assign io_bus.req_ready = w_grant;

   assign w_sel  = w_grant[1];
   assign w_ctrl = w_sel ? io_bus.req_ctrl1  : io_bus.req_ctrl0;
   assign w_src1 = w_sel ? io_bus.req_src1_1 : io_bus.req_src1_0;
   assign w_src2 = w_sel ? io_bus.req_src2_1 : io_bus.req_src2_0;

   alu u_alu (
      .i_ctrl   (w_ctrl),
      .i_src1   (w_src1),
      .i_src2   (w_src2),
      .o_result (w_result)
   );

   assign w_err = ~is_legal_ctrl(w_ctrl);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid   <= 2'b00;
         r_rsp_err     <= 2'b00;
         r_rsp_data[0] <= '0;
         r_rsp_data[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_grant[i]) begin
               r_rsp_valid[i] <= 1'b1;
               r_rsp_err[i]   <= w_err;
               r_rsp_data[i]  <= w_result;
            end else if (io_bus.rsp_ready[i]) begin
               r_rsp_valid[i] <= 1'b0;
               r_rsp_err[i]   <= 1'b0;
            end
         end
      end
   end

   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_err   = r_rsp_err;
   assign io_bus.rsp_data0 = r_rsp_data[0];
   assign io_bus.rsp_data1 = r_rsp_data[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed cases plus random traffic, checked
// cycle by cycle against a behavioural model of arbitration, slots and ALU results.
module tb_alu_share_ctrl;

   logic clk;
   logic rst;

   alu_share_ctrl_if u_if ();

   alu_share_ctrl u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (u_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] exp_q0 [$];
   logic [32:0] exp_q1 [$];
   logic [1:0]  m_rsp_valid = 2'b00;
   logic        m_ptr       = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {err, data} straight from the operation definitions.
   function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [31:0] r;
      logic        err;
      sh  = b % 32;
      err = 1'b0;
      case (c)
         4'd0:    r = a + b;
         4'd8:    r = a - b;
         4'd1:    r = a << sh;
         4'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    r = (a < b) ? 32'd1 : 32'd0;
         4'd4:    r = a ^ b;
         4'd5:    r = a >> sh;
         4'd13:   r = $signed(a) >>> sh;
         4'd6:    r = a | b;
         4'd7:    r = a & b;
         4'd9:    r = b;
         default: begin
            r   = a + b;
            err = 1'b1;
         end
      endcase
      return {err, r};
   endfunction

   // Monitor: predicts grants and slot occupancy, pops expected results on consumption.
   initial begin : monitor
      logic [1:0]  elig;
      logic [1:0]  exp_g;
      logic [32:0] e;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         check("rsp_valid", {30'd0, u_if.rsp_valid}, {30'd0, m_rsp_valid});
         if (rst) begin
            check("ready_in_reset", {30'd0, u_if.req_ready}, 32'd0);
            m_rsp_valid = 2'b00;
            m_ptr       = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
         end else begin
            elig = u_if.req_valid & (~m_rsp_valid | u_if.rsp_ready);
            if (elig == 2'b11) exp_g = m_ptr ? 2'b10 : 2'b01;
            else               exp_g = elig;
            check("grant", {30'd0, u_if.req_ready}, {30'd0, exp_g});
            for (int i = 0; i < 2; i++) begin
               if (m_rsp_valid[i] && u_if.rsp_ready[i]) begin
                  if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                     check("rsp_unexpected", 32'd1, 32'd0);
                  end else begin
                     e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     d = (i == 0) ? u_if.rsp_data0 : u_if.rsp_data1;
                     check("rsp_data", d, e[31:0]);
                     check("rsp_err", {31'd0, u_if.rsp_err[i]}, {31'd0, e[32]});
                  end
               end
            end
            if (exp_g[0]) exp_q0.push_back(ref_alu(u_if.req_ctrl0, u_if.req_src1_0,
                                                   u_if.req_src2_0));
            if (exp_g[1]) exp_q1.push_back(ref_alu(u_if.req_ctrl1, u_if.req_src1_1,
                                                   u_if.req_src2_1));
            for (int i = 0; i < 2; i++) begin
               if (exp_g[i])               m_rsp_valid[i] = 1'b1;
               else if (u_if.rsp_ready[i]) m_rsp_valid[i] = 1'b0;
            end
            if (exp_g[0])      m_ptr = 1'b1;
            else if (exp_g[1]) m_ptr = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b);
      if (i == 0) begin
         u_if.req_valid[0] = v;
         u_if.req_ctrl0    = c;
         u_if.req_src1_0   = a;
         u_if.req_src2_0   = b;
      end else begin
         u_if.req_valid[1] = v;
         u_if.req_ctrl1    = c;
         u_if.req_src1_1   = a;
         u_if.req_src2_1   = b;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      u_if.req_valid = 2'b00;
      step();
      rst = 1'b0;
   endtask

   task automatic single_op(input int i, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_d,
                            input logic exp_e, input string name);
      logic [31:0] d;
      u_if.rsp_ready = 2'b11;
      set_req(i, 1'b1, c, a, b);
      @(negedge clk);
      check({name, "_ready"}, {30'd0, u_if.req_ready}, (i == 0) ? 32'd1 : 32'd2);
      step();
      set_req(i, 1'b0, c, a, b);
      @(negedge clk);
      d = (i == 0) ? u_if.rsp_data0 : u_if.rsp_data1;
      check({name, "_valid"}, {31'd0, u_if.rsp_valid[i]}, 32'd1);
      check({name, "_data"}, d, exp_d);
      check({name, "_err"}, {31'd0, u_if.rsp_err[i]}, {31'd0, exp_e});
      step();
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction

   initial begin : stimulus
      logic [1:0]  acc;
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      rst            = 1'b1;
      u_if.req_valid = 2'b00;
      u_if.rsp_ready = 2'b00;
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      step();
      step();
      rst = 1'b0;

      // Single ops and boundary values.
      single_op(0, 4'd0,  32'h5,         32'h3,         32'h8,         1'b0, "single_add");
      single_op(1, 4'd2,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, "slt_neg");
      single_op(0, 4'd3,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, "sltu_max");
      single_op(1, 4'd1,  32'h1,         32'h21,        32'h2,         1'b0, "sll_mask");
      single_op(0, 4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, "add_wrap");
      single_op(1, 4'd9,  32'h0,         32'h1234_5000, 32'h1234_5000, 1'b0, "lui");
      single_op(0, 4'hF,  32'h2,         32'h2,         32'h4,         1'b1, "illegal");

      // Contention: strict alternation starting with r0.
      do_reset();
      u_if.rsp_ready = 2'b11;
      set_req(0, 1'b1, 4'd8,  32'd10,        32'd3);
      set_req(1, 1'b1, 4'd13, 32'h8000_0000, 32'd4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("cont_grant", {30'd0, u_if.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k == 1) check("cont_sub", u_if.rsp_data0, 32'd7);
         if (k == 2) check("cont_sra", u_if.rsp_data1, 32'hF800_0000);
         step();
      end
      u_if.req_valid = 2'b00;
      step();

      // Backpressure on r0, then drain-and-refill.
      do_reset();
      u_if.rsp_ready = 2'b10;
      set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
      @(negedge clk);
      check("bp_first", {30'd0, u_if.req_ready}, 32'd1);
      step();
      set_req(0, 1'b1, 4'd4, 32'h0000_F0F0, 32'h0000_0FF0);
      for (int k = 0; k < 4; k++) begin
         set_req(1, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
         @(negedge clk);
         check("bp_r1_grant", {30'd0, u_if.req_ready}, 32'd2);
         step();
      end
      u_if.rsp_ready = 2'b11;
      @(negedge clk);
      check("bp_refill", {30'd0, u_if.req_ready}, 32'd1);
      step();
      u_if.req_valid = 2'b00;
      step();
      step();

      // Reset with both slots holding results.
      u_if.rsp_ready = 2'b00;
      set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
      set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);
      step();
      step();
      u_if.req_valid = 2'b00;
      @(negedge clk);
      check("mid_both_full", {30'd0, u_if.rsp_valid}, 32'd3);
      step();
      rst = 1'b1;
      u_if.req_valid = 2'b11;
      @(negedge clk);
      check("rst_ready", {30'd0, u_if.req_ready}, 32'd0);
      step();
      @(negedge clk);
      check("rst_valid", {30'd0, u_if.rsp_valid}, 32'd0);
      check("rst_ready2", {30'd0, u_if.req_ready}, 32'd0);
      check("rst_data0", u_if.rsp_data0, 32'd0);
      check("rst_err", {30'd0, u_if.rsp_err}, 32'd0);
      step();
      rst = 1'b0;
      u_if.rsp_ready = 2'b11;
      @(negedge clk);
      check("post_rst_r0_first", {30'd0, u_if.req_ready}, 32'd1);
      step();
      u_if.req_valid[0] = 1'b0;
      step();
      u_if.req_valid = 2'b00;
      step();

      // Random traffic with random response backpressure and one mid-run reset.
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         acc = u_if.req_ready & u_if.req_valid;
         step();
         rst = (cyc == 200 || cyc == 201);
         for (int i = 0; i < 2; i++) begin
            if (!u_if.req_valid[i] || acc[i]) begin
               c = 4'($urandom_range(0, 15));
               a = rand_operand();
               b = rand_operand();
               set_req(i, ($urandom_range(0, 99) < 70), c, a, b);
            end
         end
         u_if.rsp_ready = 2'($urandom);
      end

      // Drain everything and confirm the scoreboard is empty.
      rst = 1'b0;
      u_if.req_valid = 2'b00;
      u_if.rsp_ready = 2'b11;
      repeat (4) step();
      check("drain_q0", exp_q0.size(), 32'd0);
      check("drain_q1", exp_q1.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester front end that time-shares one combinational ALU instance between the integer pipeline (requester 0) and an auxiliary unit such as address generation or a multi-cycle sequencer (requester 1). Each requester gets a valid/ready request channel and a one-entry registered response channel. A round-robin grant selects at most one request per cycle, drives the shared ALU, and latches the result into the winner's response register.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control code width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accepted this cycle (one-hot or zero)
- req_ctrl0 / req_ctrl1  in  CTRL_W  ALU control code per requester
- req_src1_0 / req_src1_1  in  DATA_W  operand 1 per requester
- req_src2_0 / req_src2_1  in  DATA_W  operand 2 per requester
- rsp_valid  out  2  response register holds a result
- rsp_ready  in  2  requester consumes response
- rsp_data0 / rsp_data1  out  DATA_W  registered ALU result
- rsp_err  out  2  ctrl code of the held result was undefined (result is ADD)

## Operation
- Requester i is eligible when req_valid[i]=1 and its response slot is free: rsp_valid[i]=0, or rsp_valid[i]&rsp_ready[i]=1 in the same cycle (drain-and-refill).
- Round-robin: a 1-bit priority pointer names the preferred requester. If both are eligible, the preferred one wins. If exactly one is eligible, it wins. After any grant to i, the pointer moves to 1-i; with no grant, the pointer holds.
- req_ready[i] = grant[i], combinational in the same cycle. A handshake occurs when req_valid[i]&req_ready[i]. req_valid must not depend on req_ready. Once raised, req_valid and its payload hold until accepted.
- Granted operands and ctrl are muxed into the single ALU.
- Defined codes (package constants): ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LUI 1001 (result = src2).
- Any other code yields src1+src2 with rsp_err set.
- Shift amount is src2[4:0]. Add and sub wrap modulo 2^DATA_W. SLT/SLTU return 0 or 1, zero-extended.
- Response register i: loads the ALU output and err flag on grant[i]. Clears when rsp_ready[i] is high and there is no concurrent grant[i]. Holds otherwise.
- Output values while rsp_valid=0 are don't-care but stable.

## Timing
- Request-to-response latency is 1 cycle: handshake at edge N, so rsp_valid is high after edge N.
- Throughput: each requester can issue every cycle if it keeps rsp_ready high. With both requesters continuously active, each gets alternate cycles (50/50).
- Backpressure: if rsp_ready[i]=0 while rsp_valid[i]=1, requester i is ineligible and the other may take every cycle.
- Reset: while rst=1, req_ready=00, rsp_valid=00, rsp_err=00, rsp_data=0, and the pointer is 0.
- Reset mid-operation discards held results and in-flight requests. There is no partial state.
- The first cycle after reset with both requesting grants requester 0.

## Structure
- Package alu_pkg:
  - alu_ctrl_e enum with the 11 codes above.
  - DATA_W/CTRL_W localparams.
  - is_legal_ctrl() function.
- Sub-module rr_arb2: two eligibility inputs, grant[1:0], internal pointer, advance on grant, with clk/rst.
- The shared ALU is instantiated once, unmodified.
- Operand mux, err decode and the two response registers live in the top.

## Test plan
- Single op: r0 sends ADD 0x0000_0005 + 0x0000_0003 -> req_ready[0] the same cycle; rsp_data0=0x8 and rsp_err[0]=0 one cycle later.
- Contention: both valid every cycle with rsp_ready=11; r0 sends SUB 10-3 and r1 sends SRA 0x8000_0000>>4.
  - Grants must go r0, r1, r0, ...
  - Results must be 7 and 0xF800_0000.
- Backpressure: r0 holds rsp_ready[0]=0 with a result pending while r1 requests every cycle.
  - r1 must be granted every cycle.
  - r0's new request must not be accepted until rsp_ready[0]=1, then in that same cycle (drain-and-refill).
- Boundaries:
  - SLT 0xFFFF_FFFF<1 -> 1.
  - SLTU 0xFFFF_FFFF<1 -> 0.
  - SLL 1 by src2=0x21 -> 2 (shift amount 1).
  - ADD 0xFFFF_FFFF+1 -> 0.
  - LUI src2=0x1234_5000 -> 0x1234_5000.
- Illegal code 1111 with 2+2 -> rsp_data=4, rsp_err=1.
- Reset mid-stream: assert rst with both rsp_valid set -> the next cycle shows rsp_valid=00 and req_ready=00. After release, a simultaneous request is granted to r0 first.
